// File: rtl/player_fsm_if.sv
// Turn/status bundle for one duel player.
// The master side (opponent logic or bench) drives the turn inputs.
// The slave side (player_fsm) returns the registered player status.
interface player_fsm_if #(
    parameter int HLT_W = 2,
    parameter int POS_W = 2
);
    logic             en;       // turn enable, active low
    logic             sw;       // turn strobe
    logic [2:0]       act;      // own action
    logic [2:0]       op_act;   // opponent action
    logic [POS_W-1:0] op_pos;   // opponent position
    logic [HLT_W-1:0] hlt;      // current health
    logic [POS_W-1:0] pos;      // current position
    logic             stunned;  // high while stunned
    logic             ko;       // high once knocked out
    logic             hit;      // one-cycle pulse after a damaging turn

    modport master (
        output en, sw, act, op_act, op_pos,
        input  hlt, pos, stunned, ko, hit
    );

    modport slave (
        input  en, sw, act, op_act, op_pos,
        output hlt, pos, stunned, ko, hit
    );
endinterface

// File: rtl/player_fsm.sv
// Per-player duel state engine: health, track position, stun and knock-out.
// Each qualified turn (!en && sw on a rising clock) first applies the player's
// own action, then resolves the opponent's punch or kick against the updated
// position, and finally updates the ALIVE/STUN/KO state.
// Optional feature: define BLOCK_EN to make action 7 a block that halves
// incoming damage; without it, action 7 behaves exactly like "none".
module player_fsm #(
    parameter int HLT_W      = 2,
    parameter int MAX_HLT    = 3,
    parameter int POS_W      = 2,
    parameter int NUM_POS    = 3,
    parameter int PUNCH_DMG  = 2,
    parameter int KICK_DMG   = 1,
    parameter int STUN_TURNS = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    player_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_J    = 3'd1,
        ACT_K    = 3'd2,
        ACT_P    = 3'd3,
        ACT_W    = 3'd4,
        ACT_MF   = 3'd5,
        ACT_MB   = 3'd6,
        ACT_BLK  = 3'd7
    } act_e;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_STUN  = 2'd1,
        ST_KO    = 2'd2
    } state_e;

    localparam int SC_W = (STUN_TURNS > 0) ? $clog2(STUN_TURNS + 1) : 1;

    localparam logic [HLT_W-1:0] MAX_V   = HLT_W'(MAX_HLT);
    localparam logic [HLT_W:0]   PUNCH_V = (HLT_W+1)'(PUNCH_DMG);
    localparam logic [HLT_W:0]   KICK_V  = (HLT_W+1)'(KICK_DMG);
    localparam logic [POS_W-1:0] FRONT   = POS_W'(NUM_POS - 1);
    localparam logic [SC_W-1:0]  STUN_V  = SC_W'(STUN_TURNS);

`ifdef BLOCK_EN
    localparam bit BLK_ON = 1'b1;
`else
    localparam bit BLK_ON = 1'b0;
`endif

    state_e           r_state,  w_state_nxt;
    logic [HLT_W-1:0] r_hlt,    w_hlt_nxt;
    logic [POS_W-1:0] r_pos,    w_pos_nxt;
    act_e             r_prev_act, w_prev_nxt;
    logic [SC_W-1:0]  r_stun_cnt, w_cnt_nxt;
    logic             r_hit,    w_hit_nxt;

    logic             w_turn;
    act_e             w_act_in;
    act_e             w_eff;
    logic [HLT_W-1:0] w_h1;
    logic [HLT_W-1:0] w_h2;
    logic [POS_W-1:0] w_p1;
    logic [HLT_W:0]   w_dmg;
    logic             w_punch_rng;
    logic             w_kick_rng;
    logic             w_dodge;
    logic             w_block;

    assign w_turn   = !bus.en && bus.sw;
    // Without the block feature, action 7 collapses onto "none" at the input.
    assign w_act_in = (!BLK_ON && (bus.act == 3'd7)) ? ACT_NONE : act_e'(bus.act);

    // State register: synchronous reset wins over any turn in the same cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (i_rst) begin
            r_state    <= ST_ALIVE;
            r_hlt      <= MAX_V;
            r_pos      <= '0;
            r_prev_act <= ACT_NONE;
            r_stun_cnt <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hlt      <= w_hlt_nxt;
            r_pos      <= w_pos_nxt;
            r_prev_act <= w_prev_nxt;
            r_stun_cnt <= w_cnt_nxt;
            r_hit      <= w_hit_nxt;
        end
    end

    // Turn resolution: own update, then hit resolution on the updated position, then state update.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_hlt_nxt   = r_hlt;
        w_pos_nxt   = r_pos;
        w_prev_nxt  = r_prev_act;
        w_cnt_nxt   = r_stun_cnt;
        w_hit_nxt   = 1'b0;
        w_eff       = ACT_NONE;
        w_h1        = r_hlt;
        w_h2        = r_hlt;
        w_p1        = r_pos;
        w_dmg       = '0;
        w_punch_rng = 1'b0;
        w_kick_rng  = 1'b0;
        w_dodge     = 1'b0;
        w_block     = 1'b0;

        if (w_turn && (r_state != ST_KO)) begin
            // A stunned player acts as if it chose "none".
            w_eff = (r_state == ST_ALIVE) ? w_act_in : ACT_NONE;

            // Own update: heal on a second consecutive wait, then movement.
            if ((w_eff == ACT_W) && (r_prev_act == ACT_W) && (r_hlt < MAX_V))
                w_h1 = r_hlt + HLT_W'(1);
            if ((w_eff == ACT_MF) && (r_pos < FRONT))
                w_p1 = r_pos + POS_W'(1);
            else if ((w_eff == ACT_MB) && (r_pos != '0))
                w_p1 = r_pos - POS_W'(1);

            w_punch_rng = (w_p1 == FRONT) && (bus.op_pos == FRONT);
            w_kick_rng  = ((w_p1 == FRONT) && (bus.op_pos != '0)) ||
                          ((bus.op_pos == FRONT) && (w_p1 != '0));
            w_dodge     = (w_eff == ACT_J) || (w_eff == ACT_MB);
            w_block     = BLK_ON && (w_eff == ACT_BLK);
            w_pos_nxt   = w_p1;

            // Hit resolution; a counter pushes this player one step back.
            if ((bus.op_act == 3'(ACT_P)) && w_punch_rng) begin
                if (w_eff == ACT_P)
                    w_pos_nxt = (w_p1 != '0) ? (w_p1 - POS_W'(1)) : '0;
                else if (!w_dodge)
                    w_dmg = w_block ? (PUNCH_V >> 1) : PUNCH_V;
            end else if ((bus.op_act == 3'(ACT_K)) && w_kick_rng) begin
                if (w_eff == ACT_K)
                    w_pos_nxt = (w_p1 != '0) ? (w_p1 - POS_W'(1)) : '0;
                else if (w_dodge || ((w_eff == ACT_P) && w_punch_rng))
                    w_dmg = '0;
                else
                    w_dmg = w_block ? (KICK_V >> 1) : KICK_V;
            end

            // Damage saturates at zero health.
            w_h2      = ({1'b0, w_h1} > w_dmg) ? (w_h1 - w_dmg[HLT_W-1:0]) : '0;
            w_hlt_nxt = w_h2;
            w_hit_nxt = (w_dmg != '0);
            w_prev_nxt = w_eff;

            // State update: KO beats stun; fresh damage reloads the stun counter.
            if (w_h2 == '0) begin
                w_state_nxt = ST_KO;
                w_cnt_nxt   = '0;
            end else if ((w_dmg != '0) && (STUN_TURNS > 0)) begin
                w_state_nxt = ST_STUN;
                w_cnt_nxt   = STUN_V;
            end else if (r_state == ST_STUN) begin
                w_cnt_nxt = r_stun_cnt - SC_W'(1);
                if (r_stun_cnt == SC_W'(1))
                    w_state_nxt = ST_ALIVE;
            end
        end
    end

    assign bus.hlt     = r_hlt;
    assign bus.pos     = r_pos;
    assign bus.stunned = (r_state == ST_STUN);
    assign bus.ko      = (r_state == ST_KO);
    assign bus.hit     = r_hit;

endmodule

// File: tb/tb_player_fsm.sv
// Self-checking bench for player_fsm: directed duel scenarios followed by
// randomized turns, all compared against an integer-level player model.
module tb_player_fsm;

    localparam int MAX   = 3;
    localparam int FRONT = 2;
    localparam int PUNCH = 2;
    localparam int KICK  = 1;
    localparam int STUN  = 2;

`ifdef BLOCK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Reference model: plain integers, stun tracked as "turns left".
    int m_hlt, m_pos, m_stun_left, m_prev;
    bit m_ko, m_hit;

    player_fsm_if #(.HLT_W(2), .POS_W(2)) bus ();

    player_fsm dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hlt = MAX; m_pos = 0; m_stun_left = 0; m_prev = 0; m_ko = 0; m_hit = 0;
    endtask

    task automatic model_turn(input int a, input int oa, input int op);
        int  eff, dmg;
        bit  punch, kick, dodge;
        if (m_ko) begin
            m_hit = 0;
            return;
        end
        eff = (m_stun_left > 0) ? 0 : a;
        if (eff == 7 && !BLK) eff = 0;
        if (eff == 4 && m_prev == 4) m_hlt = (m_hlt + 1 > MAX) ? MAX : m_hlt + 1;
        if (eff == 5 && m_pos < FRONT) m_pos = m_pos + 1;
        if (eff == 6 && m_pos > 0) m_pos = m_pos - 1;
        punch = (m_pos == FRONT) && (op == FRONT);
        kick  = (m_pos == FRONT && op != 0) || (op == FRONT && m_pos != 0);
        dodge = (eff == 1) || (eff == 6);
        dmg   = 0;
        if (oa == 3 && punch) begin
            if (eff == 3) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
            else if (!dodge) dmg = PUNCH;
        end else if (oa == 2 && kick) begin
            if (eff == 2) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
            else if (!dodge && !(eff == 3 && punch)) dmg = KICK;
        end
        if (eff == 7) dmg = dmg / 2;
        m_hlt = (m_hlt > dmg) ? m_hlt - dmg : 0;
        if (m_hlt == 0) begin
            m_ko = 1;
            m_stun_left = 0;
        end else if (dmg > 0 && STUN > 0) begin
            m_stun_left = STUN;
        end else if (m_stun_left > 0) begin
            m_stun_left = m_stun_left - 1;
        end
        m_prev = eff;
        m_hit  = (dmg > 0);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, compare all outputs 1 time unit later.
    task automatic step(input string tag, input bit rs, input bit en, input bit sw,
                        input int a, input int oa, input int op);
        @(negedge clk);
        rst        = rs;
        bus.en     = en;
        bus.sw     = sw;
        bus.act    = 3'(a);
        bus.op_act = 3'(oa);
        bus.op_pos = 2'(op);
        @(posedge clk);
        if (rs) model_reset();
        else if (!en && sw) model_turn(a, oa, op);
        else m_hit = 0;
        #1;
        check({tag, ".hlt"},     32'(bus.hlt),     32'(m_hlt));
        check({tag, ".pos"},     32'(bus.pos),     32'(m_pos));
        check({tag, ".stunned"}, 32'(bus.stunned), 32'(m_stun_left > 0));
        check({tag, ".ko"},      32'(bus.ko),      32'(m_ko));
        check({tag, ".hit"},     32'(bus.hit),     32'(m_hit));
    endtask

    // Shorthand for a qualified turn.
    task automatic turn(input string tag, input int a, input int oa, input int op);
        step(tag, 1'b0, 1'b0, 1'b1, a, oa, op);
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b1; bus.sw = 1'b0;
        bus.act = '0; bus.op_act = '0; bus.op_pos = '0;
        model_reset();

        // Reset state.
        step("rst0", 1'b1, 1'b1, 1'b0, 0, 0, 0);
        step("rst1", 1'b1, 1'b1, 1'b0, 0, 0, 0);
        check("rst_hlt", 32'(bus.hlt), 32'd3);
        check("rst_pos", 32'(bus.pos), 32'd0);

        // Walk to the front, then take a punch.
        turn("mf1", 5, 0, 0);
        turn("mf2", 5, 0, 0);
        turn("punched", 0, 3, 2);
        check("punch_hlt", 32'(bus.hlt), 32'd1);
        check("punch_hit", 32'(bus.hit), 32'd1);
        check("punch_stun", 32'(bus.stunned), 32'd1);
        // Non-turn clocks hold state and clear hit even with an attack present.
        step("hold_sw0", 1'b0, 1'b0, 1'b0, 5, 3, 2);
        step("hold_en1", 1'b0, 1'b1, 1'b1, 5, 3, 2);
        check("hold_hit", 32'(bus.hit), 32'd0);
        turn("stun1", 5, 0, 0);
        check("stun1_still", 32'(bus.stunned), 32'd1);
        turn("stun2", 0, 0, 0);
        check("stun2_clear", 32'(bus.stunned), 32'd0);

        // Healing needs consecutive waits and saturates at the maximum.
        turn("w1", 4, 0, 0);
        turn("w2", 4, 0, 0);
        check("heal_2", 32'(bus.hlt), 32'd2);
        turn("w3", 4, 0, 0);
        check("heal_3", 32'(bus.hlt), 32'd3);
        turn("w4", 4, 0, 0);
        check("heal_sat", 32'(bus.hlt), 32'd3);

        // Counters: punch vs punch at the front, then kick vs kick.
        turn("pp", 3, 3, 2);
        check("pp_pos", 32'(bus.pos), 32'd1);
        check("pp_hlt", 32'(bus.hlt), 32'd3);
        turn("kk", 2, 2, 2);
        check("kk_pos", 32'(bus.pos), 32'd0);
        check("kk_hit", 32'(bus.hit), 32'd0);
        // Move back at home saturates at zero.
        turn("mb0", 6, 0, 2);
        check("mb_sat", 32'(bus.pos), 32'd0);

        // Repeated kicks down to knock-out, KO is absorbing.
        turn("mf_k", 5, 0, 0);
        turn("kick1", 0, 2, 2);
        turn("kick2", 0, 2, 2);
        turn("kick3", 0, 2, 2);
        check("ko_flag", 32'(bus.ko), 32'd1);
        check("ko_hlt", 32'(bus.hlt), 32'd0);
        turn("ko_w1", 4, 2, 2);
        turn("ko_w2", 4, 3, 2);
        check("ko_stays", 32'(bus.hlt), 32'd0);
        // Reset wins over a simultaneous turn.
        step("rst_turn", 1'b1, 1'b0, 1'b1, 5, 0, 0);
        check("rst_win_pos", 32'(bus.pos), 32'd0);

        // Action 7 against a punch and a kick in range.
        turn("b_mf1", 5, 0, 0);
        turn("b_mf2", 5, 0, 0);
        turn("blk_p", 7, 3, 2);
        check("blk_punch", 32'(bus.hlt), BLK ? 32'd2 : 32'd1);
        step("rst_b", 1'b1, 1'b1, 1'b0, 0, 0, 0);
        turn("b_mf3", 5, 0, 0);
        turn("b_mf4", 5, 0, 0);
        turn("blk_k", 7, 2, 2);
        check("blk_kick", 32'(bus.hlt), BLK ? 32'd3 : 32'd2);
        check("blk_kick_hit", 32'(bus.hit), BLK ? 32'd0 : 32'd1);

        // Randomized turns with occasional resets.
        step("rnd_rst", 1'b1, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
